// File: rtl/mul_pkg.sv
// Shared types for the HI/LO multiply path: FSM states, iteration count
// and the HI/LO write-enable encoding consumed by the HI/LO unit.
package mul_pkg;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  typedef enum logic [1:0] {
    HILO_WE_NONE = 2'b00,
    HILO_WE_LO   = 2'b01,
    HILO_WE_HI   = 2'b10,
    HILO_WE_BOTH = 2'b11
  } hilo_we_e;

endpackage

// File: rtl/mul.sv
// Radix-2 shift-add 32x32 multiplier (MULT/MULTU) for the HI/LO unit.
// Define MUL_EARLY_TERM_EN to stop once the remaining multiplier is zero.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic             sign,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(MUL_ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_nx, res;
  logic               last;

  // 0x80000000 maps onto itself, which is correct as an unsigned magnitude
  assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

  assign acc_nx = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign res    = neg_q ? -acc_nx : acc_nx;

`ifdef MUL_EARLY_TERM_EN
  assign last = (cnt_q == CNT_LAST) || ((mplr_q >> 1) == '0);
`else
  assign last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, a_mag};
          mplr_d  = b_mag;
          neg_d   = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_CALC;
        end
      end
      MUL_CALC: begin
        if (!start) begin
          state_d = MUL_IDLE;
        end else begin
          acc_d   = acc_nx;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (last) begin
            state_d      = MUL_DONE;
            {hi_d, lo_d} = res;
          end
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = (state_q == MUL_DONE);
  assign busy = (state_q == MUL_CALC);

endmodule

// File: tb/tb_mul.sv
// Directed self-checking bench for the sequential multiplier.
// Latency expectations follow MUL_EARLY_TERM_EN when it is defined.
module tb_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        done, busy;

  int nchk = 0;
  int nerr = 0;

  mul dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .start(start),
    .sign (sign),
    .hi   (hi),
    .lo   (lo),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_iter(input logic [31:0] bv, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (s && bv[31]) ? -bv : bv;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic s,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit hold);
    int cyc;
    int bcy;
    int it;
    it = exp_iter(bv, s);
    @(negedge clk);
    a = av; b = bv; sign = s; start = 1'b1;
    cyc = 0; bcy = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcy++;
    end
    if (!hold) start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(it + 1));
    chk({tag, " busy cycles"}, 64'(bcy), 64'(it));
    chk({tag, " hi"}, {32'h0, hi}, {32'h0, eh});
    chk({tag, " lo"}, {32'h0, lo}, {32'h0, el});
    @(negedge clk);
    chk({tag, " done fall"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    int saw;
    #12;
    chk("reset hi", {32'h0, hi}, 64'h0);
    chk("reset lo", {32'h0, lo}, 64'h0);
    chk("reset done", {63'h0, done}, 64'h0);
    chk("reset busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    run_op("u7x6", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, 1'b1);
    chk("b2b idle busy", {63'h0, busy}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b relaunch busy", {63'h0, busy}, 64'h1);
    start = 1'b0;
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw++;
    end
    chk("abort1 no done", 64'(saw), 64'h0);
    chk("abort1 busy", {63'h0, busy}, 64'h0);
    chk("abort1 lo", {32'h0, lo}, 64'h2A);

    run_op("s-3x5", 32'hFFFFFFFD, 32'h5, 1'b1,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("uFFxFF", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
           32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("s-1x-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
           32'h0, 32'h1, 1'b0);
    run_op("sminxmin", 32'h80000000, 32'h80000000, 1'b1,
           32'h40000000, 32'h0, 1'b0);
    run_op("sminx1", 32'h80000000, 32'h1, 1'b1,
           32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("u12345x1", 32'd12345, 32'd1, 1'b0, 32'h0, 32'd12345, 1'b0);
    run_op("ux0", 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_op("u3xmsb", 32'd3, 32'h80000000, 1'b0,
           32'h1, 32'h80000000, 1'b0);

    @(negedge clk);
    a = 32'd5; b = 32'h80000000; sign = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw++;
    end
    chk("abort2 no done", 64'(saw), 64'h0);
    chk("abort2 busy", {63'h0, busy}, 64'h0);
    chk("abort2 hi", {32'h0, hi}, 64'h1);
    chk("abort2 lo", {32'h0, lo}, 64'h80000000);

    @(negedge clk);
    a = 32'd7; b = 32'h80000000; sign = 1'b0; start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("mid busy", {63'h0, busy}, 64'h1);
    rst = 1'b0;
    #1;
    chk("rst hi", {32'h0, hi}, 64'h0);
    chk("rst lo", {32'h0, lo}, 64'h0);
    chk("rst done", {63'h0, done}, 64'h0);
    chk("rst busy", {63'h0, busy}, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op("post-rst", 32'd9, 32'd11, 1'b0, 32'h0, 32'd99, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mul.md
# mul

Sequential 32x32 multiplier for the MIPS EX stage, the multiplicative counterpart of the iterative divider; together they back the HI/LO unit. It executes MULT (signed) and MULTU (unsigned) with a radix-2 shift-add datapath over 32 iterations. It uses the same start/sign/done handshake as the divider, so the EX stall logic drives both blocks identically.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a  input  WIDTH  multiplicand; sampled only at launch.
- b  input  WIDTH  multiplier; sampled only at launch.
- start  input  1  level request; held high by EX until done.
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled at launch.
- hi  output  WIDTH  product[63:32]; registered.
- lo  output  WIDTH  product[31:0]; registered.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high while state is CALC.

## Operation
- States: IDLE, CALC, DONE. The encoding is 2 bits; done and busy decode directly from the state flops.
- IDLE with start=1:
  - Latch |a| and |b| when sign=1, raw a and b when sign=0.
  - Latch neg = sign & (a[31]^b[31]).
  - Clear the 64-bit accumulator, set cnt=0, go to CALC.
- CALC, one iteration per cycle:
  - If mplr[0]=1, acc += mcand (64-bit, zero-extended).
  - mcand <<= 1; mplr >>= 1; cnt++.
  - On the last iteration (cnt==31), go to DONE.
  - On the same edge, write {hi,lo} = neg ? (~acc_next+1) : acc_next.
- DONE: assert done for one cycle, then return to IDLE unconditionally.
- If start is still high in IDLE after DONE, a new operation launches. EX must drop start in the done cycle.
- Abort: start=0 in CALC returns to IDLE on the next edge. hi/lo keep their previous value and done is not pulsed.
- hi/lo change only at completion; they hold between operations.
- Arithmetic rules:
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.
  - Negation is 64-bit two's complement.
  - The accumulator never overflows 64 bits.
- start is ignored in DONE.

## Timing
- Reset values: hi=0, lo=0, done=0, busy=0, state=IDLE, cnt=0.
- rst asserted mid-operation takes effect immediately. Any result in flight is discarded; there is no done.
- Edge E0 (IDLE, start=1): launch.
- Edges E1..E32: iterations; busy=1 in the cycles between E0 and E32.
- hi/lo are valid and done=1 in the cycle following E32, i.e. 33 cycles after the launch edge.
- done falls at E33.
- Back-to-back operations are allowed: with start held continuously, the next launch occurs at E34.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - CALC also exits when the next multiplier value (mplr>>1) is zero, writing the result on that same edge.
  - Iterations = index of the highest set bit of |b| + 1, with a minimum of 1 (b=0 takes 1 iteration).
  - done follows the final iteration edge by one cycle, as in the full-length case.
- MUL_EARLY_TERM_EN undefined: always 32 iterations, fixed 33-cycle latency.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package/header holds:
  - state encodings MUL_IDLE, MUL_CALC, MUL_DONE;
  - MUL_ITER = 32;
  - the hi/lo write-enable encoding used by the HI/LO unit.
- No sub-module is needed. The block is one FSM plus a flat shift-add datapath; magnitude and negate are inline expressions.

## Test plan
- Unsigned 7 x 6 with start held: done pulses 33 cycles after launch, hi=0x00000000, lo=0x0000002A, busy high for exactly 32 cycles.
- Signed -3 x 5 (0xFFFFFFFD, 0x00000005): hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. The same operands signed (-1 x -1) give hi=0, lo=1.
- Signed 0x80000000 x 0x80000000: hi=0x40000000, lo=0x00000000. Signed 0x80000000 x 1: hi=0xFFFFFFFF, lo=0x80000000.
- Abort and reset:
  - Drop start at iteration 10: no done; hi/lo unchanged from the prior result; the state returns to IDLE.
  - Assert rst at iteration 20: all outputs read 0 immediately.
- With MUL_EARLY_TERM_EN, 12345 x 1: done one cycle after the single iteration edge, lo=12345.
- With MUL_EARLY_TERM_EN, b=0: lo=0 after 1 iteration.
- With MUL_EARLY_TERM_EN, b=0x80000000: full 32 iterations.
